// File: rtl/mc_control_pkg.sv
// mc_control_pkg: shared types and encodings for the multi-cycle MIPS control FSM.
//   mc_state_t    - FSM state enumeration
//   Op*           - supported IR[31:26] opcodes
//   PcSrc*, RegDst*, MemToReg*, AluSrcB*, AluOp* - datapath mux/ALU encodings
//   cnt_width()   - wait-counter width for a given TIMEOUT (never below 1 bit)
package mc_control_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecute,
        StAluWb,
        StAddiExec,
        StAddiWb,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StBranch,
        StJump,
        StJal
    } mc_state_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDst31 = 2'b10;

    localparam logic [1:0] MemToRegAluOut = 2'b00;
    localparam logic [1:0] MemToRegMdr    = 2'b01;
    localparam logic [1:0] MemToRegPc     = 2'b10;

    localparam logic [1:0] AluSrcBReg   = 2'b00;
    localparam logic [1:0] AluSrcBFour  = 2'b01;
    localparam logic [1:0] AluSrcBImm   = 2'b10;
    localparam logic [1:0] AluSrcBImmSh = 2'b11;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // A zero TIMEOUT still needs a 1-bit counter so the ports stay legal.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mc_control_mem_wait_timer.sv
// mem_wait_timer: saturating wait-cycle counter for one memory access.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - restart the count (takes priority over inc)
//   inc       - count one more wait cycle
//   at_limit  - count equals TIMEOUT (never asserted when TIMEOUT is 0)
module mem_wait_timer
    import mc_control_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int unsigned CntW = cnt_width(TIMEOUT);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CntW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (TIMEOUT != 0) && (cnt == CntW'(TIMEOUT));

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the MIPS datapath. Sequences each instruction through
// fetch/decode/execute/memory/writeback and decodes the datapath controls combinationally
// from the current state. Memory accesses handshake on mem_ready with an optional timeout.
//   Parameter TIMEOUT: max wait cycles per memory access, 0 disables the timeout.
//   Inputs : clk, rst (async, active high), opcode (IR[31:26]), zero (ALU flag), mem_ready.
//   Outputs: mem_req, mem_write, i_or_d, ir_write, pc_write, pc_src, reg_dst, mem_to_reg,
//            reg_write, alu_src_a, alu_src_b, alu_op, illegal (pulse), bus_err (sticky).
//   Build option: define MC_CONTROL_JAL_EN to decode opcode 000011 as jal; otherwise it is
//   treated as an illegal opcode.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       bus_err
);

    mc_state_t state;
    logic      in_mem;
    logic      at_limit;
    logic      timeout_fire;
    logic      wait_clr;
    logic      wait_inc;

    assign in_mem = (state == StFetch) || (state == StMemRead) || (state == StMemWrite);

    // mem_ready wins over a timeout reached in the same cycle.
    assign timeout_fire = in_mem && !mem_ready && at_limit;

    // Clearing whenever the access ends (or outside memory states) guarantees a fresh count on
    // entry, including the back-to-back MEM_WRITE -> FETCH case.
    assign wait_clr = !in_mem || mem_ready || timeout_fire;
    assign wait_inc = in_mem && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (wait_clr),
        .inc      (wait_inc),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StFetch;
            bus_err <= 1'b0;
        end else begin
            if (timeout_fire) begin
                bus_err <= 1'b1;
            end
            unique case (state)
                StFetch: begin
                    // On timeout we simply stay: the retry reuses the unchanged PC.
                    if (mem_ready) state <= StDecode;
                end
                StDecode: begin
                    case (opcode)
                        OpRtype:      state <= StExecute;
                        OpLw, OpSw:   state <= StMemAddr;
                        OpBeq, OpBne: state <= StBranch;
                        OpAddi:       state <= StAddiExec;
                        OpJ:          state <= StJump;
`ifdef MC_CONTROL_JAL_EN
                        OpJal:        state <= StJal;
`endif
                        default:      state <= StFetch;
                    endcase
                end
                StExecute:  state <= StAluWb;
                StAluWb:    state <= StFetch;
                StAddiExec: state <= StAddiWb;
                StAddiWb:   state <= StFetch;
                StMemAddr:  state <= (opcode == OpLw) ? StMemRead : StMemWrite;
                StMemRead: begin
                    if (mem_ready) begin
                        state <= StMemWb;
                    end else if (timeout_fire) begin
                        state <= StFetch;
                    end
                end
                StMemWb: state <= StFetch;
                StMemWrite: begin
                    if (mem_ready || timeout_fire) state <= StFetch;
                end
                StBranch: state <= StFetch;
                StJump:   state <= StFetch;
                StJal:    state <= StFetch;
                default:  state <= StFetch;
            endcase
        end
    end

    // Outputs are forced low while rst is high so an in-flight access drops immediately.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PcSrcAlu;
        reg_dst    = RegDstRt;
        mem_to_reg = MemToRegAluOut;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = AluSrcBReg;
        alu_op     = AluOpAdd;
        illegal    = 1'b0;
        if (!rst) begin
            unique case (state)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = AluSrcBFour;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: begin
                    alu_src_b = AluSrcBImmSh;
                    case (opcode)
                        OpRtype, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ: illegal = 1'b0;
`ifdef MC_CONTROL_JAL_EN
                        OpJal:   illegal = 1'b0;
`endif
                        default: illegal = 1'b1;
                    endcase
                end
                StExecute: begin
                    alu_src_a = 1'b1;
                    alu_op    = AluOpFunct;
                end
                StAluWb: begin
                    reg_dst   = RegDstRd;
                    reg_write = 1'b1;
                end
                StAddiExec, StMemAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = AluSrcBImm;
                end
                StAddiWb: begin
                    reg_write = 1'b1;
                end
                StMemRead: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                StMemWb: begin
                    mem_to_reg = MemToRegMdr;
                    reg_write  = 1'b1;
                end
                StMemWrite: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                StBranch: begin
                    alu_src_a = 1'b1;
                    alu_op    = AluOpSub;
                    pc_src    = PcSrcAluOut;
                    pc_write  = (opcode == OpBne) ? !zero : zero;
                end
                StJump: begin
                    pc_write = 1'b1;
                    pc_src   = PcSrcJump;
                end
                StJal: begin
`ifdef MC_CONTROL_JAL_EN
                    reg_dst    = RegDst31;
                    mem_to_reg = MemToRegPc;
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PcSrcJump;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM that replaces the single-cycle opcode decoder in the next-generation MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives the shared-memory, IR, PC, register-file and ALU multiplexer controls. It handshakes with a variable-latency memory, with an optional timeout. It sits between the instruction register (the opcode source) and the multi-cycle datapath.

## Interface
- `TIMEOUT`, default 16: maximum wait cycles for `mem_ready` per access; 0 disables the timeout.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]; stable from DECODE until the next FETCH completes.
- `zero` in 1: ALU zero flag, valid in BRANCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: qualifies `mem_req` as a write.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the IR.
- `pc_write` out 1: load the PC.
- `pc_src` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `reg_dst` out 2: destination register; 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg` out 2: write-back source; 00 = ALUOut, 01 = MDR, 10 = PC.
- `reg_write` out 1: register-file write.
- `alu_src_a` out 1: ALU A source; 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B source; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `bus_err` out 1: sticky memory-timeout flag; cleared only by `rst`.

## Operation
States, transitions and outputs (any output not listed is 0):
- FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00. If `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE. Otherwise stay.
- DECODE: `alu_src_b`=11 to precompute the branch target. Next state by opcode:
  - 000000 → EXECUTE
  - 100011 / 101011 → MEM_ADDR
  - 000100 / 000101 → BRANCH
  - 001000 → ADDI_EXEC
  - 000010 → JUMP
  - anything else → FETCH with `illegal`=1.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → ALU_WB.
- ALU_WB: `reg_dst`=01, `reg_write`=1 → FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → ADDI_WB.
- ADDI_WB: `reg_dst`=00, `reg_write`=1 → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10 → MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_req`=1, `i_or_d`=1. When `mem_ready`=1 → MEM_WB.
- MEM_WB: `reg_dst`=00, `mem_to_reg`=01, `reg_write`=1 → FETCH.
- MEM_WRITE: `mem_req`=1, `mem_write`=1, `i_or_d`=1. When `mem_ready`=1 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01. `pc_write` = `zero` for beq, `~zero` for bne → FETCH.
- JUMP: `pc_write`=1, `pc_src`=10 → FETCH.

Memory timeout:
- A wait counter clears on entry to each memory state and increments on every cycle with `mem_ready`=0.
- When the counter reaches `TIMEOUT` (and `TIMEOUT`≠0): set `bus_err`, abandon the access and go to FETCH with no `ir_write`, `pc_write` or `reg_write`.
- A fetch timeout therefore retries at the same PC.
- If `mem_ready` goes high in the same cycle the counter reaches `TIMEOUT`, the access completes normally; `mem_ready` wins.
- Counter width is $clog2(TIMEOUT+1) and the counter saturates, never wrapping.

## Timing
- All outputs are decoded combinationally from state, with `mem_ready`, `zero` and `opcode` qualifying where listed above. There are no output registers.
- While `rst` is high: state=FETCH, counter=0, `bus_err`=0, and every output is forced to 0.
- After `rst` deasserts, FETCH outputs appear in the same cycle.
- Instruction latency in cycles with zero-wait memory (`mem_ready` constantly high):
  - R-type, addi, sw: 4
  - lw: 5
  - beq, bne, j, jal: 3
- Each memory wait cycle adds 1 cycle.
- `mem_req` holds high, with address and write selects stable, until the cycle in which `mem_ready` is sampled high or the timeout fires.
- Asserting `rst` mid-instruction abandons the instruction immediately, with no partial `reg_write` or `pc_write` after the reset edge.

## Configuration
- `MC_CONTROL_JAL_EN` defined: opcode 000011 in DECODE → JAL state.
  - JAL drives `reg_dst`=10, `mem_to_reg`=10, `reg_write`=1, `pc_write`=1, `pc_src`=10, then → FETCH (3 cycles).
- `MC_CONTROL_JAL_EN` undefined: 000011 is illegal (`illegal` pulse, → FETCH). Port widths are unchanged.

## Structure
- Package `mc_control_pkg`:
  - state enum `mc_state_t`
  - opcode localparams
  - `alu_op`, `pc_src`, `reg_dst`, `mem_to_reg` and `alu_src_b` encodings
- One sub-module, `mem_wait_timer`: the saturating counter with clear, increment and `TIMEOUT` compare.

## Test plan
- R-type (000000), `mem_ready` always 1 → states FETCH, DECODE, EXECUTE, ALU_WB. Cycle 4: `reg_write`=1, `reg_dst`=01. Cycle 5: FETCH.
- lw with `mem_ready` low 3 cycles in MEM_READ → 8 cycles total; `mem_req`/`i_or_d`=1 held throughout; `mem_to_reg`=01 in MEM_WB.
- beq with `zero`=0, then bne with `zero`=0 → `pc_write`=0 then 1 in BRANCH; `pc_src`=01.
- Opcode 111111 → `illegal` pulses for 1 cycle in DECODE, next state FETCH, no `reg_write`.
- `TIMEOUT`=4, `mem_ready` held 0 in FETCH → `bus_err` rises after 4 wait cycles, no `ir_write`/`pc_write`, FETCH retries. `bus_err` stays 1 until `rst`.
- `rst` asserted during MEM_WRITE → `mem_req`/`mem_write` drop asynchronously. After release: FETCH, `bus_err`=0. With `MC_CONTROL_JAL_EN`, 000011 writes $31 with `mem_to_reg`=10.
